// File: rtl/load_store_ctrl.sv
// Load/store sequencer between execute and the data-memory bus: alignment and width checks,
// valid/ack handshake with timeout, lane steering and load extension.
module load_store_ctrl #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  width_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [1:0]  err_cause_o,
    output logic        dmem_valid_o,
    input  logic        dmem_ack_i,
    output logic [31:0] dmem_addr_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_sel_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;

    localparam logic [15:0] TO_LAST = 16'(BUS_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        flushed_q, flushed_d;
    logic [1:0]  cause_d;
    logic        width_ok, misaligned, accept, flush_now;

    logic [29:0] addr_p1;
    logic        we_p1;
    logic [3:0]  sel_p1;
    logic [31:0] wdata_p1;
    logic [2:0]  width_p1;
    logic [1:0]  off_p1;
    logic [31:0] rdata_p2;
    logic [1:0]  cause_p2;

    function automatic logic [3:0] lane_sel(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   lane_sel = 4'b0001 << off;
            2'b01:   lane_sel = 4'b0011 << {off[1], 1'b0};
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   lane_data = {4{d[7:0]}};
            2'b01:   lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    // width[2] marks the unsigned variants (BU/HU)
    function automatic logic [31:0] load_extend(input logic [2:0] w, input logic [1:0] off,
                                                input logic [31:0] d);
        logic [31:0] s;
        s = d >> {off, 3'b000};
        case (w[1:0])
            2'b00:   load_extend = w[2] ? {24'd0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
            2'b01:   load_extend = w[2] ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: load_extend = s;
        endcase
    endfunction

    assign width_ok   = (width_i[1:0] != 2'b11) && !(width_i[2] && (we_i || width_i[1]));
    assign misaligned = ((width_i[1:0] == 2'b01) && addr_i[0]) ||
                        ((width_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    assign accept     = (state_q == IDLE) && req_i && !flush_i && width_ok && !misaligned;
    assign flush_now  = flushed_q || flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flushed_q <= flushed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flushed_d = flushed_q;
        cause_d   = 2'b00;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                flushed_d = 1'b0;
                if (req_i && !flush_i) begin
                    if (!width_ok) begin
                        state_d = ERR;
                        cause_d = 2'b10;
                    end else if (misaligned) begin
                        state_d = ERR;
                        cause_d = 2'b01;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                flushed_d = flush_now;
                if (dmem_ack_i) begin
                    state_d   = flush_now ? IDLE : RESP;
                    cnt_d     = '0;
                    flushed_d = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = flush_now ? IDLE : ERR;
                    cause_d   = 2'b11;
                    cnt_d     = '0;
                    flushed_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // p1: request captured on acceptance; p2: response captured on ack or fault
    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_p1  <= addr_i[31:2];
            we_p1    <= we_i;
            sel_p1   <= lane_sel(width_i[1:0], addr_i[1:0]);
            wdata_p1 <= lane_data(width_i[1:0], wdata_i);
            width_p1 <= width_i;
            off_p1   <= addr_i[1:0];
        end
        if ((state_q == BUSY) && dmem_ack_i) begin
            rdata_p2 <= we_p1 ? 32'd0 : load_extend(width_p1, off_p1, dmem_rdata_i);
        end
        cause_p2 <= cause_d;
    end

    assign stall_o      = ((state_q == IDLE) && req_i && !flush_i) || (state_q == BUSY);
    assign done_o       = (state_q == RESP);
    assign err_o        = (state_q == ERR);
    assign rdata_o      = (state_q == RESP) ? rdata_p2 : 32'd0;
    assign err_cause_o  = (state_q == ERR) ? cause_p2 : 2'b00;
    assign dmem_valid_o = (state_q == BUSY);
    assign dmem_addr_o  = dmem_valid_o ? {addr_p1, 2'b00} : 32'd0;
    assign dmem_we_o    = dmem_valid_o && we_p1;
    assign dmem_sel_o   = dmem_valid_o ? sel_p1 : 4'd0;
    assign dmem_wdata_o = dmem_valid_o ? wdata_p1 : 32'd0;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Scoreboard bench for load_store_ctrl: a behavioural model queues expected responses,
// a monitor pops and compares them; a bus responder supplies ack with programmable wait states.
module tb_load_store_ctrl;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i, req_i, we_i, flush_i, dmem_ack_i;
    logic [2:0]  width_i;
    logic [31:0] addr_i, wdata_i, dmem_rdata_i;
    logic        stall_o, done_o, err_o, dmem_valid_o, dmem_we_o;
    logic [31:0] rdata_o, dmem_addr_o, dmem_wdata_o;
    logic [1:0]  err_cause_o;
    logic [3:0]  dmem_sel_o;

    load_store_ctrl #(.BUS_TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .width_i(width_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i), .stall_o(stall_o),
        .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o), .err_cause_o(err_cause_o),
        .dmem_valid_o(dmem_valid_o), .dmem_ack_i(dmem_ack_i), .dmem_addr_o(dmem_addr_o),
        .dmem_we_o(dmem_we_o), .dmem_sel_o(dmem_sel_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rdata_i(dmem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_err;
        logic [1:0]  cause;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_vec = 0, n_bad = 0;
    int          cyc = 0, start_cyc = 0;
    bit          bus_exp = 0;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_sel;
    logic        exp_we;
    int          ack_wait = -1;
    logic [31:0] bus_rdata = 32'd0;
    bit          force_ack = 0;
    int          wcnt = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: access size from func3, alignment by modulo, extension by arithmetic
    task automatic model(input bit we, input logic [2:0] w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int waits,
                         input int flush_at, output exp_t e, output bit on_bus,
                         output bit exp_resp, output logic [3:0] sel, output logic [31:0] bwd);
        int          size;
        bit          legal;
        logic [31:0] v;
        legal    = we ? (w inside {3'd0, 3'd1, 3'd2}) : (w inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size     = (w % 4 == 0) ? 1 : (w % 4 == 1) ? 2 : 4;
        e.is_err = 1'b0; e.cause = 2'd0; e.rdata = 32'd0; e.lat = 0;
        on_bus   = 1'b0; exp_resp = 1'b1;
        sel      = 4'd0; bwd = 32'd0;
        if (!legal) begin
            e.is_err = 1'b1; e.cause = 2'd2; e.lat = 1;
        end else if (a % size != 0) begin
            e.is_err = 1'b1; e.cause = 2'd1; e.lat = 1;
        end else begin
            on_bus = 1'b1;
            sel    = 4'(((1 << size) - 1) << (a % 4));
            bwd    = (size == 1) ? (wd & 32'hFF) * 32'h01010101 :
                     (size == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
            if (flush_at == 2 && (waits < 0 || waits >= 1)) begin
                exp_resp = 1'b0;
            end else if (waits < 0 || waits >= TO) begin
                e.is_err = 1'b1; e.cause = 2'd3; e.lat = TO + 1;
            end else begin
                e.lat = 2 + waits;
                if (!we) begin
                    v = rd / (32'd1 << (8 * (a % 4)));
                    if (size == 1) begin
                        v = v % 256;
                        if (w < 4 && v >= 128) v = v - 256;
                    end else if (size == 2) begin
                        v = v % 65536;
                        if (w < 4 && v >= 32768) v = v - 65536;
                    end
                    e.rdata = v;
                end
            end
        end
    endtask

    task automatic do_op(input bit we, input logic [2:0] w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int waits,
                         input int flush_at);
        exp_t        e;
        bit          on_bus, exp_resp, fin;
        logic [3:0]  sel;
        logic [31:0] bwd;
        model(we, w, a, wd, rd, waits, flush_at, e, on_bus, exp_resp, sel, bwd);
        if (exp_resp) sb_q.push_back(e);
        bus_exp   = on_bus;
        exp_addr  = {a[31:2], 2'b00};
        exp_sel   = sel;
        exp_wdata = bwd;
        exp_we    = we;
        ack_wait  = waits;
        bus_rdata = rd;
        req_i = 1'b1; we_i = we; width_i = w; addr_i = a; wdata_i = wd;
        start_cyc = cyc;
        fin = 1'b0;
        for (int k = 0; k < 20 && !fin; k++) begin
            if (flush_at > 0 && k == flush_at) begin
                flush_i = 1'b1;
                req_i   = 1'b0;
            end else begin
                flush_i = 1'b0;
            end
            @(negedge clk_i);
            if (k == 0) check("stall_cycle0", 32'(stall_o), 32'd1);
            if (!stall_o) fin = 1'b1;
            @(posedge clk_i);
            #1;
        end
        flush_i = 1'b0;
        req_i   = 1'b0;
        bus_exp = 1'b0;
        if (!fin) check("op_cycle_budget", 32'd0, 32'd1);
    endtask

    // Bus responder: ack on the (ack_wait+1)-th valid cycle; rdata is junk except on ack
    initial begin
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'd0;
        forever begin
            @(posedge clk_i);
            #1;
            dmem_ack_i   = force_ack;
            dmem_rdata_i = $urandom;
            if (dmem_valid_o) begin
                if (wcnt == ack_wait) begin
                    dmem_ack_i   = 1'b1;
                    dmem_rdata_i = bus_rdata;
                end
                wcnt++;
            end else begin
                wcnt = 0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (done_o || err_o) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got done=%0b err=%0b, expected none (cycle %0d)",
                             done_o, err_o, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("resp_kind", {30'd0, done_o, err_o}, mon_e.is_err ? 32'd1 : 32'd2);
                    check("err_cause", 32'(err_cause_o), mon_e.is_err ? 32'(mon_e.cause) : 32'd0);
                    check("rdata", rdata_o, mon_e.is_err ? 32'd0 : mon_e.rdata);
                    check("latency", 32'(cyc - start_cyc), 32'(mon_e.lat));
                end
            end else begin
                check("quiet_rdata", rdata_o, 32'd0);
                check("quiet_cause", 32'(err_cause_o), 32'd0);
            end
            if (dmem_valid_o) begin
                if (!bus_exp) begin
                    check("unexpected_bus", 32'd1, 32'd0);
                end else begin
                    check("bus_addr", dmem_addr_o, exp_addr);
                    check("bus_sel", 32'(dmem_sel_o), 32'(exp_sel));
                    check("bus_wdata", dmem_wdata_o, exp_wdata);
                    check("bus_we", 32'(dmem_we_o), 32'(exp_we));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rw;
        int         rwait;
        int         rflush;
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; width_i = 3'd0; addr_i = 32'd0;
        wdata_i = 32'd0; flush_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_ctrl", {27'd0, stall_o, done_o, err_o, dmem_valid_o, dmem_we_o}, 32'd0);
        check("reset_data", rdata_o | dmem_addr_o | dmem_wdata_o, 32'd0);
        check("reset_sel_cause", {26'd0, dmem_sel_o, err_cause_o}, 32'd0);
        @(posedge clk_i);
        #1;

        // Directed cases from the access scenarios
        do_op(1'b0, 3'b010, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 0, 0);
        do_op(1'b0, 3'b000, 32'h0000_2003, 32'd0, 32'h80FF_1234, 0, 0);
        do_op(1'b0, 3'b100, 32'h0000_2003, 32'd0, 32'h80FF_1234, 0, 0);
        do_op(1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h5555_5555, 2, 0);
        do_op(1'b0, 3'b010, 32'h0000_0001, 32'd0, 32'd0, 0, 0);
        do_op(1'b1, 3'b100, 32'h0000_0000, 32'd0, 32'd0, 0, 0);
        do_op(1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'd0, -1, 0);
        do_op(1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'hCAFE_F00D, 3, 0);
        do_op(1'b0, 3'b101, 32'h0000_3002, 32'd0, 32'h8765_4321, 2, 2);
        do_op(1'b0, 3'b001, 32'h0000_3002, 32'd0, 32'h8765_4321, 0, 0);

        // Flush in IDLE suppresses the request
        req_i = 1'b1; flush_i = 1'b1; we_i = 1'b0; width_i = 3'b010; addr_i = 32'h10;
        @(negedge clk_i);
        check("idle_flush_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i);
        #1 req_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        check("idle_flush_valid", 32'(dmem_valid_o), 32'd0);
        @(posedge clk_i);
        #1;

        // Reset mid-transaction, then a late ack must be ignored
        bus_exp = 1'b1; exp_addr = 32'h4000; exp_sel = 4'hF; exp_we = 1'b0;
        exp_wdata = 32'h55AA_55AA; ack_wait = -1;
        req_i = 1'b1; we_i = 1'b0; width_i = 3'b010; addr_i = 32'h4000; wdata_i = 32'h55AA_55AA;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1; req_i = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b0; bus_exp = 1'b0;
        @(negedge clk_i);
        check("rst_busy_ctrl", {27'd0, stall_o, done_o, err_o, dmem_valid_o, dmem_we_o}, 32'd0);
        check("rst_busy_data", dmem_addr_o | dmem_wdata_o | {28'd0, dmem_sel_o}, 32'd0);
        force_ack = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        force_ack = 1'b0;
        check("late_ack_done", {30'd0, done_o, dmem_valid_o}, 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("late_ack_after", {30'd0, done_o, err_o}, 32'd0);
        @(posedge clk_i);
        #1;

        // Randomized accesses, back to back
        for (int i = 0; i < 60; i++) begin
            rw     = 3'($urandom_range(0, 7));
            rwait  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
            rflush = ($urandom_range(0, 7) == 0) ? 2 : 0;
            do_op(1'($urandom_range(0, 1)), rw, $urandom, $urandom, $urandom, rwait, rflush);
        end

        repeat (3) @(posedge clk_i);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
